xillybus_read32_stream_fifo: RTL and testbench
==============================================

// Module: xillybus_read32_stream_fifo
// PURPOSE
// - Upstream feeder for the core's 32-bit host-read stream (user_r_read_32_*).
// - Buffers an application valid/ready word stream in a synchronous FIFO.
// - Presents the data/empty/eof/rden/open FIFO interface the core consumes.
// - Converts an application end-of-stream marker (s_tlast) into a host-visible EOF after the FIFO drains.
// PARAMETERS
// - DEPTH   512  FIFO depth in 32-bit words; power of two, >= 4.
// - ADDR_W  9    log2(DEPTH); pointer width. The count is ADDR_W+1 bits.
// PORTS
// - bus_clk                in   1       Single clock for all logic; shared with the core.
// - bus_rst                in   1       Reset; synchronous, active-high.
// - s_tdata                in   32      Application data word.
// - s_tvalid               in   1       s_tdata is valid.
// - s_tlast                in   1       Qualified by s_tvalid; the word is the last before EOF.
// - s_tready               out  1       Block accepts the word this cycle.
// - user_r_read_32_rden    in   1       Pop request from the core.
// - user_r_read_32_open    in   1       Host has the device file open.
// - user_r_read_32_data    out  32      Popped word; valid the cycle after an accepted rden.
// - user_r_read_32_empty   out  1       FIFO holds no words.
// - user_r_read_32_eof     out  1       End of stream reached; asserted only while empty=1.
// - fill_level             out  ADDR_W+1  Current word count, for status and debug.
// BEHAVIOUR
// - Reset values: data=0, empty=1, eof=0, s_tready=0, fill_level=0, state=CLOSED, pointers=0.
// - FSM states: CLOSED, STREAM, DRAIN, EOF.
//   - CLOSED -> STREAM when open=1.
//   - STREAM -> DRAIN when a word with s_tlast=1 is accepted.
//   - DRAIN -> EOF when count==0. This includes the same cycle a pop empties the FIFO.
//   - Any state -> CLOSED when open=0. This has priority over every other transition.
// - CLOSED:
//   - Pointers and count are cleared every cycle (flush). s_tready=0. eof=0.
//   - rden is ignored. Data output holds its last value.
// - Push: s_tready = (state==STREAM) && (count<DEPTH). A push occurs when s_tvalid && s_tready.
// - Pop:
//   - A pop occurs when rden && count!=0 && state!=CLOSED.
//   - rden while empty is ignored: no pointer move and no underflow.
// - Read latency: registered RAM read. user_r_read_32_data updates exactly 1 cycle after the pop
//   and holds its value until the next pop.
// - Simultaneous push and pop: both pointers advance and count is unchanged. This is legal when
//   full (count==DEPTH is not a blocker to the pop). s_tready stays 0 while full, even with a pop
//   in the same cycle; no combinational rden->s_tready path.
// - Pointers wrap modulo DEPTH (natural ADDR_W overflow). count is updated by +1, -1 or 0.
// - empty = (count==0), registered alongside count with no extra latency.
// - eof = (state==EOF). It is never asserted while count!=0. In EOF, s_tready=0 until the host closes.
// - s_tlast on the word that fills the last free slot: the word is accepted and the FSM enters DRAIN.
// - Reset mid-transfer: everything returns to reset values on the next edge. In-flight words are lost.
// - Close mid-transfer (open 1->0): flush on the next edge. Reopen starts a fresh stream in STREAM.
// STRUCTURE
// - Shared package xillybus_user_pkg holds:
//   - XB_DATA_W=32.
//   - State encoding localparams ST_CLOSED=2'd0, ST_STREAM=2'd1, ST_DRAIN=2'd2, ST_EOF=2'd3.
//   - clog2 helper function.
// - One sub-module: xillybus_sdp_ram. It is a simple dual-port RAM with DEPTH x 32 bits, one write
//   port and one registered read port, on bus_clk. It maps to block RAM.
// - Pointers, count, FSM and handshake logic stay in this module.
// TESTING
// - Basic flow: open=1, push 0x00000001..0x00000008, then rden for 8 cycles -> data 1..8 each 1 cycle
//   after its rden; empty=1 after the 8th pop; eof=0.
// - Full boundary (DEPTH=16): push 17 words with rden=0 -> s_tready drops after the 16th word and
//   fill_level=16. One pop -> s_tready=1 on the next cycle; the 17th word is accepted.
// - EOF: push 3 words, the third with s_tlast=1 -> s_tready=0 and state=DRAIN. Pop 3 -> eof=1 the
//   cycle empty=1. While open stays 1, eof stays 1 and s_tready stays 0.
// - Underflow: rden=1 for 5 cycles on an empty FIFO -> pointers and fill_level unchanged, data unchanged.
// - Close mid-stream: 10 words buffered, open->0 -> next cycle fill_level=0, empty=1, s_tready=0.
//   Reopen -> STREAM; the first pop returns the first post-reopen word.
// - Reset: bus_rst=1 for 1 cycle with 5 words buffered and state=DRAIN -> all outputs at reset values
//   on the next edge.

Source files
------------

// File: rtl/xillybus_user_pkg.sv
// xillybus_user_pkg: shared widths, stream FSM encoding and helpers for Xillybus user-side FIFOs.
package xillybus_user_pkg;
    localparam int XB_DATA_W = 32;
    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_EOF    = 2'd3;
    typedef enum logic [1:0] {
        XB_CLOSED = ST_CLOSED,
        XB_STREAM = ST_STREAM,
        XB_DRAIN  = ST_DRAIN,
        XB_EOF    = ST_EOF
    } xb_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/xillybus_sdp_ram.sv
// xillybus_sdp_ram: simple dual-port RAM, one write port and one registered read port.
module xillybus_sdp_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // Output register only moves on a read, so the last popped word is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/xillybus_read32_stream_fifo.sv
// xillybus_read32_stream_fifo: buffers a valid/ready word stream for the core's 32-bit read FIFO port
// and turns the application's tlast into a host EOF once the buffer has drained.
module xillybus_read32_stream_fifo
    import xillybus_user_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic [XB_DATA_W-1:0] s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    input  logic                 user_r_read_32_rden,
    input  logic                 user_r_read_32_open,
    output logic [XB_DATA_W-1:0] user_r_read_32_data,
    output logic                 user_r_read_32_empty,
    output logic                 user_r_read_32_eof,
    output logic [ADDR_W:0]      fill_level
);
    xb_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count, w_count_nxt;
    logic              w_push, w_pop, w_flush;

    assign s_tready = (r_state == XB_STREAM) && (r_count < (ADDR_W+1)'(DEPTH));
    assign w_push   = s_tvalid && s_tready;
    assign w_pop    = user_r_read_32_rden && (r_count != '0) && (r_state != XB_CLOSED);
    // A close is seen one edge late, so the flush also covers the cycle open drops.
    assign w_flush  = !user_r_read_32_open || (r_state == XB_CLOSED);
    assign w_count_nxt = w_flush ? '0 : r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        if (!user_r_read_32_open) w_state_nxt = XB_CLOSED;
        else begin
            case (r_state)
                XB_CLOSED: w_state_nxt = XB_STREAM;
                XB_STREAM: if (w_push && s_tlast) w_state_nxt = XB_DRAIN;
                XB_DRAIN:  if (w_count_nxt == '0) w_state_nxt = XB_EOF;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state  <= XB_CLOSED;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_flush ? '0 : r_wr_ptr + ADDR_W'(w_push);
            r_rd_ptr <= w_flush ? '0 : r_rd_ptr + ADDR_W'(w_pop);
        end
    end

    assign user_r_read_32_empty = (r_count == '0);
    assign user_r_read_32_eof   = (r_state == XB_EOF);
    assign fill_level           = r_count;

    xillybus_sdp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (XB_DATA_W)
    ) u_ram (
        .i_clk   (bus_clk),
        .i_rst   (bus_rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_tdata),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (user_r_read_32_data)
    );
endmodule

// File: tb/tb_xillybus_read32_stream_fifo.sv
// tb_xillybus_read32_stream_fifo: directed and random stimulus against a queue-based stream model.
module tb_xillybus_read32_stream_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   tdata = '0;
    logic          tvalid = 1'b0, tlast = 1'b0, rden = 1'b0, open = 1'b0;
    logic          tready, empty, eof;
    logic [31:0]   rdata;
    logic [AW:0]   fill;

    xillybus_read32_stream_fifo #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .bus_clk              (clk),
        .bus_rst              (rst),
        .s_tdata              (tdata),
        .s_tvalid             (tvalid),
        .s_tlast              (tlast),
        .s_tready             (tready),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_open  (open),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_empty (empty),
        .user_r_read_32_eof   (eof),
        .fill_level           (fill)
    );

    always #5 clk = ~clk;

    typedef enum {M_CLOSED, M_STREAM, M_DRAIN, M_EOF} mst_t;
    mst_t        mst = M_CLOSED;
    logic [31:0] q[$];
    logic [31:0] mdata = '0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit rdy, push, pop;
        rdy  = (mst == M_STREAM) && (q.size() < DEPTH);
        push = tvalid && rdy;
        pop  = rden && (q.size() != 0) && (mst != M_CLOSED);
        @(posedge clk);
        if (rst) begin
            q.delete();
            mst   = M_CLOSED;
            mdata = '0;
        end else if (!open) begin
            if (pop) mdata = q[0];
            q.delete();
            mst = M_CLOSED;
        end else if (mst == M_CLOSED) begin
            q.delete();
            mst = M_STREAM;
        end else begin
            if (pop) mdata = q.pop_front();
            if (push) q.push_back(tdata);
            if (mst == M_STREAM && push && tlast) mst = M_DRAIN;
            else if (mst == M_DRAIN && q.size() == 0) mst = M_EOF;
        end
        #1;
        check("tready", 32'(tready), 32'((mst == M_STREAM) && (q.size() < DEPTH)));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("eof", 32'(eof), 32'(mst == M_EOF));
        check("fill_level", 32'(fill), 32'(q.size()));
        check("data", rdata, mdata);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        rden   = r;
        step();
    endtask

    initial begin
        step();
        step();
        check("reset_data", rdata, 32'h0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_tready", 32'(tready), 32'd0);
        rst = 1'b0;
        open = 1'b1;
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) drive(1, 32'(i), 0, 0);
        for (int i = 1; i <= 8; i++) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("basic_last_data", rdata, 32'd8);
        check("basic_eof", 32'(eof), 32'd0);

        for (int i = 0; i < 17; i++) drive(1, 32'(100 + i), 0, 0);
        check("full_fill", 32'(fill), 32'd16);
        check("full_tready", 32'(tready), 32'd0);
        drive(1, 116, 0, 1);
        check("after_pop_tready", 32'(tready), 32'd1);
        drive(1, 116, 0, 0);
        check("refill_fill", 32'(fill), 32'd16);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1);
        check("drain_last_data", rdata, 32'd116);

        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
        check("underflow_data", rdata, 32'd116);
        check("underflow_fill", 32'(fill), 32'd0);

        drive(1, 32'hA1, 0, 0);
        drive(1, 32'hA2, 0, 0);
        drive(1, 32'hA3, 1, 0);
        check("drain_tready", 32'(tready), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
        check("eof_set", 32'(eof), 32'd1);
        for (int i = 0; i < 3; i++) drive(1, 32'hBAD, 0, 0);
        check("eof_hold", 32'(eof), 32'd1);
        check("eof_tready", 32'(tready), 32'd0);

        open = 1'b0;
        drive(0, 0, 0, 0);
        open = 1'b1;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 32'(300 + i), 0, 0);
        open = 1'b0;
        drive(0, 0, 0, 0);
        check("close_fill", 32'(fill), 32'd0);
        open = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 32'hC0DE, 0, 0);
        drive(0, 0, 0, 1);
        check("reopen_data", rdata, 32'hC0DE);

        for (int i = 0; i < 5; i++) drive(1, 32'(400 + i), i == 4, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_data", rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            open = ($urandom_range(0, 99) > 2);
            rst  = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 31) == 0,
                  $urandom_range(0, 2) != 0);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
